rr_encoder: RTL and testbench

Parametrised, registered N-to-log2(N) encoder with round-robin priority and a valid/ack output handshake. It is the next generation of the team's fixed 4-to-2 encoder. It accepts any number of simultaneously asserted request lines and emits one encoded index per accepted transaction, rotating fairness across requesters. It sits between request-producing blocks (interrupt lines, channel ready flags) and a single consumer that services one index at a time.

---
 rtl/rr_encoder_pkg.sv | 12 +
 rtl/rr_encoder_prio_pick.sv | 32 +++
 rtl/rr_encoder.sv | 81 ++++++++
 tb/tb_rr_encoder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rr_encoder_pkg.sv
// Shared constants and index-width helper for the round-robin encoder family.
package rr_encoder_pkg;

    localparam int unsigned RR_N_MAX = 256;
    localparam int unsigned RR_N_MIN = 2;

    // A lone request line would otherwise produce a zero-width index.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_encoder_prio_pick.sv
// Combinational lowest-set-bit search starting at 'start', wrapping to bit 0 when
// nothing at or above 'start' is set.
module prio_pick
    import rr_encoder_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned W = idx_w(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         any,
    output logic [W-1:0] idx
);

    always_comb begin
        any = |vec;
        idx = '0;
        // Lowest set bit overall is the wrap-around fallback.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
        // Any set bit at or above start overrides the fallback.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i] && (i >= int'(start))) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_encoder.sv
// Registered N-to-log2(N) encoder with valid/ack handshake. Round-robin priority when
// RR_ENCODER_ROUND_ROBIN_EN is defined, fixed lowest-index priority otherwise.
module rr_encoder
    import rr_encoder_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned W = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [W-1:0] y,
    output logic         valid
);

    logic [W-1:0] y_q, y_d;
    logic         valid_q, valid_d;
    logic [W-1:0] start;
    logic [W-1:0] pick;
    logic         any;
    logic         slot_free;
    logic         capture;

`ifdef RR_ENCODER_ROUND_ROBIN_EN
    logic [W-1:0] ptr_q, ptr_d;
    assign start = ptr_q;
`else
    assign start = '0;
`endif

    prio_pick #(
        .N (N)
    ) u_pick (
        .vec   (req),
        .start (start),
        .any   (any),
        .idx   (pick)
    );

    assign slot_free = ~valid_q | ack;
    assign capture   = slot_free & en & any;

    always_comb begin
        y_d     = y_q;
        valid_d = valid_q;
`ifdef RR_ENCODER_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        if (capture) begin
            y_d     = pick;
            valid_d = 1'b1;
`ifdef RR_ENCODER_ROUND_ROBIN_EN
            ptr_d   = (pick == W'(N - 1)) ? '0 : pick + W'(1);
`endif
        end else if (slot_free) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= '0;
            valid_q <= 1'b0;
`ifdef RR_ENCODER_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
`ifdef RR_ENCODER_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign y     = y_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_rr_encoder.sv
// Scoreboard bench for rr_encoder: N=8 handshake/priority scenarios plus an N=5 instance.
module tb_rr_encoder;

`ifdef RR_ENCODER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int NONE = -1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, ack;
    logic [7:0] req;
    logic [2:0] y;
    logic       valid;

    logic       en5, ack5;
    logic [4:0] req5;
    logic [2:0] y5;
    logic       valid5;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    rr_encoder #(.N(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .req   (req),
        .ack   (ack),
        .y     (y),
        .valid (valid)
    );

    rr_encoder #(.N(5)) dut5 (
        .clk   (clk),
        .rst   (rst),
        .en    (en5),
        .req   (req5),
        .ack   (ack5),
        .y     (y5),
        .valid (valid5)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs for the coming edge; a non-negative exp means a capture is expected.
    task automatic step(input logic e, input logic [7:0] r, input logic a, input int exp);
        en  = e;
        req = r;
        ack = a;
        if (exp >= 0) exp_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed transfer pops the oldest expected index.
    always @(negedge clk) begin
        if (!rst && valid && ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL transfer_unexpected: got y=%0d expected no valid output", y);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(y) != e) begin
                    errors++;
                    $display("FAIL transfer_y: got %0d expected %0d", y, e);
                end
            end
        end
    end

    int rr_seq[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    int rr5[4]    = '{1, 3, 4, 1};

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        req  = '0;
        ack  = 1'b0;
        en5  = 1'b0;
        req5 = '0;
        ack5 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", int'(valid), 0);
        check("reset_y", int'(y), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Capture, then reset mid-cycle discards the pending index.
        step(1'b1, 8'b0010_0100, 1'b0, 2);
        check("pre_reset_valid", int'(valid), 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_valid", int'(valid), 0);
        check("async_reset_y", int'(y), 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;

        // Pointer restarts at 0.
        step(1'b1, 8'b1000_0001, 1'b0, 0);
        check("first_capture_valid", int'(valid), 1);
        check("first_capture_y", int'(y), 0);

        // Fairness: all requesting with ack every cycle.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 8'hFF, 1'b1, RR ? rr_seq[i] : 0);
            check("fair_valid", int'(valid), 1);
        end
        step(1'b1, 8'h00, 1'b1, NONE);
        check("drain1_valid", int'(valid), 0);

        // Backpressure holds y stable.
        step(1'b1, 8'b0001_0100, 1'b0, 2);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'b0001_0100, 1'b0, NONE);
            check("bp_valid", int'(valid), 1);
            check("bp_y", int'(y), 2);
        end
        step(1'b1, 8'b0001_0100, 1'b1, RR ? 4 : 2);
        check("bp_next_y", int'(y), RR ? 4 : 2);
        step(1'b1, 8'h00, 1'b1, NONE);

        // Wrap: grant 6 then 0, 7, then pointer back at 0.
        step(1'b1, 8'b0100_0000, 1'b1, 6);
        step(1'b1, 8'b0000_0011, 1'b1, 0);
        check("wrap_y0", int'(y), 0);
        step(1'b1, 8'b1000_0000, 1'b1, 7);
        check("wrap_y7", int'(y), 7);
        step(1'b1, 8'b1000_0010, 1'b1, 1);
        step(1'b1, 8'b0000_0001, 1'b1, 0);
        check("single_req_y", int'(y), 0);
        step(1'b1, 8'h00, 1'b1, NONE);
        check("drain2_valid", int'(valid), 0);

        // Enable and empty request.
        step(1'b0, 8'h10, 1'b0, NONE);
        check("en_low_valid", int'(valid), 0);
        step(1'b1, 8'h00, 1'b0, NONE);
        check("req_zero_valid", int'(valid), 0);
        step(1'b1, 8'h10, 1'b0, 4);
        step(1'b0, 8'h10, 1'b0, NONE);
        check("en_low_holds_valid", int'(valid), 1);
        check("en_low_holds_y", int'(y), 4);
        step(1'b0, 8'h10, 1'b1, NONE);
        check("en_low_ack_valid", int'(valid), 0);
        step(1'b0, 8'h00, 1'b1, NONE);
        check("idle_ack_valid", int'(valid), 0);

        // Priority discrimination: bit 0 after grant of 0.
        step(1'b1, 8'h03, 1'b1, 0);
        step(1'b1, 8'h03, 1'b1, RR ? 1 : 0);
        check("prio_y", int'(y), RR ? 1 : 0);
        step(1'b1, 8'h00, 1'b1, NONE);
        check("drain3_valid", int'(valid), 0);

        // N=5 instance, req=11010 held with ack.
        check("n5_idle_valid", int'(valid5), 0);
        en5  = 1'b1;
        req5 = 5'b11010;
        ack5 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("n5_valid", int'(valid5), 1);
            check("n5_y", int'(y5), RR ? rr5[i] : 1);
        end
        en5 = 1'b0;

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
